// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the bit serializer.
// A word transfers on a rising clk edge where in_valid && in_ready; in_ready never depends on in_valid.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the 0110 sequence detector, with a one-word holding
// buffer so back-to-back words stream gap-free; idles at IDLE_BIT when starved.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  bit_serializer_if.slave  in_bus,
  output logic             x_out,
  output logic             x_active,
  output logic             word_done,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [WIDTH-1:0] buf_q, buf_n;
  logic             buf_full_q, buf_full_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             x_out_q, x_out_n;
  logic             accept, load_slot;

  assign accept    = in_bus.in_valid && !buf_full_q;
  // Load slot: idle, or the last bit of the current word is on x_out.
  assign load_slot = (state_q == IDLE) || (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cnt_q      <= '0;
      x_out_q    <= IDLE_BIT;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      buf_q      <= buf_n;
      buf_full_q <= buf_full_n;
      cnt_q      <= cnt_n;
      x_out_q    <= x_out_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    buf_n      = buf_q;
    buf_full_n = buf_full_q;
    cnt_n      = cnt_q;
    x_out_n    = IDLE_BIT;
    if (load_slot) begin
      cnt_n = '0;
      if (buf_full_q) begin
        shift_n    = buf_q;
        buf_full_n = 1'b0;
        state_n    = SHIFT;
      end else if (accept) begin
        shift_n = in_bus.in_data;
        state_n = SHIFT;
      end else begin
        state_n = IDLE;
      end
    end else begin
      if (MSB_FIRST != 0) shift_n = {shift_q[WIDTH-2:0], 1'b0};
      else                shift_n = {1'b0, shift_q[WIDTH-1:1]};
      cnt_n = cnt_q + CNT_W'(1);
      if (accept) begin
        buf_n      = in_bus.in_data;
        buf_full_n = 1'b1;
      end
    end
    // x_out is registered from the bit that will sit at the output end next cycle.
    if (state_n == SHIFT) begin
      if (MSB_FIRST != 0) x_out_n = shift_n[WIDTH-1];
      else                x_out_n = shift_n[0];
    end
  end

  assign in_bus.in_ready = !buf_full_q;
  assign x_out           = x_out_q;
  assign x_active        = (state_q == SHIFT);
  assign word_done       = (state_q == SHIFT) && (cnt_q == LAST);
  assign busy            = (state_q == SHIFT) || buf_full_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: LSB-first and MSB-first instances, scoreboard queues of
// expected {word_done, bit} pairs popped by per-instance monitors on the falling edge.
module tb_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) bus0 ();
  bit_serializer_if #(.WIDTH(W)) bus1 ();

  logic x_out0, x_active0, word_done0, busy0, state_dbg0;
  logic x_out1, x_active1, word_done1, busy1, state_dbg1;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_bus(bus0.slave),
    .x_out(x_out0), .x_active(x_active0), .word_done(word_done0),
    .busy(busy0), .state_dbg(state_dbg0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_bus(bus1.slave),
    .x_out(x_out1), .x_active(x_active1), .word_done(word_done1),
    .busy(busy1), .state_dbg(state_dbg1)
  );

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  logic [1:0] e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every data bit must match the queue head; idle cycles must show the idle level.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (x_active0) begin
        if (exp_q0.size() == 0) check("dut0_unexpected_bit", 32'd1, 32'd0);
        else begin
          e0 = exp_q0.pop_front();
          check("dut0_x_out", 32'(x_out0), 32'(e0[0]));
          check("dut0_word_done", 32'(word_done0), 32'(e0[1]));
        end
      end else begin
        check("dut0_idle_x_out", 32'(x_out0), 32'd1);
        check("dut0_idle_word_done", 32'(word_done0), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (x_active1) begin
        if (exp_q1.size() == 0) check("dut1_unexpected_bit", 32'd1, 32'd0);
        else begin
          e1 = exp_q1.pop_front();
          check("dut1_x_out", 32'(x_out1), 32'(e1[0]));
          check("dut1_word_done", 32'(word_done1), 32'(e1[1]));
        end
      end else begin
        check("dut1_idle_x_out", 32'(x_out1), 32'd1);
      end
    end
  end

  // s holds the hand-computed transmit order, first bit in s[W-1].
  task automatic push_stream(input int sel, input logic [W-1:0] s);
    for (int i = 0; i < W; i++) begin
      logic [1:0] v;
      v = {(i == W - 1), s[W-1-i]};
      if (sel == 0) exp_q0.push_back(v);
      else          exp_q1.push_back(v);
    end
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic send(input int sel, input logic [W-1:0] d, input logic [W-1:0] s, input bit hold);
    int n = 0;
    if (sel == 0) begin bus0.in_data = d; bus0.in_valid = 1'b1; end
    else          begin bus1.in_data = d; bus1.in_valid = 1'b1; end
    while (!ready_of(sel) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      push_stream(sel, s);
      #1;
    end
    if (!hold) begin
      if (sel == 0) bus0.in_valid = 1'b0;
      else          bus1.in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.in_data = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_x_out", 32'(x_out0), 32'd1);
    check("rst_x_active", 32'(x_active0), 32'd0);
    check("rst_word_done", 32'(word_done0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("rst_x_out_msb", 32'(x_out1), 32'd1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single word 8'h06, LSB first: 0,1,1,0,0,0,0,0 then idle.
    send(0, 8'h06, 8'b01100000, 1'b0);
    check("s1_active_c1", 32'(x_active0), 32'd1);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      check("s1_active", 32'(x_active0), 32'd1);
    end
    @(posedge clk); #1;
    check("s1_idle_active", 32'(x_active0), 32'd0);
    check("s1_idle_x_out", 32'(x_out0), 32'd1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back A5, 3C: 16 contiguous bits, buffer stalls in_ready until drained.
    send(0, 8'hA5, 8'b10100101, 1'b1);
    send(0, 8'h3C, 8'b00111100, 1'b0);
    check("s2_ready_low", 32'(bus0.in_ready), 32'd0);
    check("s2_busy", 32'(busy0), 32'd1);
    for (int i = 2; i < 2 * W; i++) begin
      @(posedge clk); #1;
      check("s2_no_gap", 32'(x_active0), 32'd1);
      if (i == W) check("s2_ready_back", 32'(bus0.in_ready), 32'd1);
    end
    @(posedge clk); #1;
    check("s2_end_active", 32'(x_active0), 32'd0);
    check("s2_end_busy", 32'(busy0), 32'd0);

    // MSB first with 8'h60 gives the same 0110 stream.
    send(1, 8'h60, 8'b01100000, 1'b0);
    repeat (10) @(posedge clk); #1;
    check("s3_msb_busy", 32'(busy1), 32'd0);

    // One pulse every 12 cycles: each word followed by 4 idle, non-busy cycles.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       send(0, 8'h0F, 8'b11110000, 1'b0);
        1:       send(0, 8'h81, 8'b10000001, 1'b0);
        default: send(0, 8'h12, 8'b01001000, 1'b0);
      endcase
      repeat (W - 1) @(posedge clk);
      for (int g = 0; g < 4; g++) begin
        @(posedge clk); #1;
        check("s4_gap_busy", 32'(busy0), 32'd0);
        check("s4_gap_active", 32'(x_active0), 32'd0);
      end
    end

    // Reset at bit index 3 of the first of two queued words.
    send(0, 8'hA5, 8'b10100101, 1'b1);
    send(0, 8'h3C, 8'b00111100, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    check("s5_mid_word", 32'(state_dbg0), 32'd1);
    reset_n = 1'b0;
    #1;
    check("s5_rst_x_out", 32'(x_out0), 32'd1);
    check("s5_rst_active", 32'(x_active0), 32'd0);
    check("s5_rst_busy", 32'(busy0), 32'd0);
    check("s5_rst_ready", 32'(bus0.in_ready), 32'd1);
    exp_q0.delete();
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("s5_post_busy", 32'(busy0), 32'd0);

    // Stall with in_data changing; the value at the accept edge is serialized.
    send(0, 8'h0F, 8'b11110000, 1'b1);
    send(0, 8'h81, 8'b10000001, 1'b1);
    check("s6_stalled", 32'(bus0.in_ready), 32'd0);
    begin
      int n = 0;
      bus0.in_data = 8'h12;
      while (!bus0.in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
        bus0.in_data = (n % 2 == 1) ? 8'h55 : 8'h12;
      end
      check("s6_ready_timeout", 32'(n < 50), 32'd1);
    end
    bus0.in_data = 8'hC4;
    @(posedge clk);
    push_stream(0, 8'b00100011);
    #1 bus0.in_valid = 1'b0;
    bus0.in_data = 8'hFF;

    begin
      int n = 0;
      while ((exp_q0.size() != 0 || busy0) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    repeat (3) @(posedge clk); #1;
    check("final_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("final_q1_empty", 32'(exp_q1.size()), 32'd0);
    check("final_busy", 32'(busy0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial "0110" sequence detector. Accepts parallel words on a valid/ready handshake and shifts them out one bit per clock on x_out, which connects directly to the detector's x_in.
- A one-entry holding buffer lets back-to-back words stream with no gap bits.
- When starved, the block drives a fixed idle level, so the detector always sees a defined bit.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
MSB_FIRST, 0, 0 = bit 0 of each word goes out first; 1 = bit WIDTH-1 goes out first
IDLE_BIT, 1, level driven on x_out when no word is being shifted (1 so that idle never completes a 0110 match)

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_data  in  WIDTH  parallel word to serialize
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a word this cycle; transfer occurs when in_valid && in_ready at a rising edge
x_out  out  1  serial bit stream to the detector's x_in, registered
x_active  out  1  x_out carries a data bit (0 = idle fill)
word_done  out  1  one-cycle pulse during the cycle the last bit of a word is on x_out
busy  out  1  shifter active or holding buffer occupied

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset (reset_n=0, asynchronous): state=IDLE, shifter and buffer empty. Output values during reset:
  - x_out=IDLE_BIT
  - x_active=0
  - word_done=0
  - busy=0
  - in_ready=1 (valid once reset is released)
- Storage:
  - Shift register of WIDTH bits.
  - Bit counter of width clog2(WIDTH), counting 0..WIDTH-1.
  - Holding buffer of WIDTH bits plus a buf_full flag.
- in_ready = !buf_full, combinational from registered state only. It never depends on in_valid.
- States:
  - IDLE: shifter empty; x_out=IDLE_BIT, x_active=0.
  - SHIFT: x_out is the current bit (bit 0 if MSB_FIRST=0, else bit WIDTH-1); x_active=1; counter = index of that bit.
- Load rule. A load slot exists in IDLE, and in SHIFT when counter==WIDTH-1 (last bit on x_out). At each edge with a load slot:
  - If buf_full: move the buffer into the shifter and clear buf_full. in_ready was 0, so no accept is possible.
  - Else if an accept occurs: load in_data directly into the shifter (bypass).
  - Else: go to (or stay in) IDLE.
  - Any load sets state=SHIFT and counter=0.
- Without a load slot: an accept writes in_data into the buffer and sets buf_full.
- Latency: a word accepted at edge N drives its first bit on x_out after edge N (bypass path). Its last bit appears after edge N+WIDTH-1.
- Back-to-back: with in_valid held high, consecutive words produce a continuous bit stream with zero idle cycles.
- Non-load edges in SHIFT: shift by one position toward the output end and increment the counter.
- word_done = (state==SHIFT && counter==WIDTH-1), combinational from registers.
- busy = (state==SHIFT) || buf_full.
- in_data is sampled only at the accept edge. Later changes to in_data have no effect.
- Holding in_valid high while in_ready=0 is legal. The word stays pending and is taken when in_ready rises.
- Asserting reset mid-word aborts immediately. Buffered and partially shifted data are discarded, and x_out returns to IDLE_BIT asynchronously.
- After reset is released, the first edge behaves as in IDLE.

Test Plan:
- Reset, then one accept of in_data=8'h06 with MSB_FIRST=0 -> x_out sequence 0,1,1,0,0,0,0,0 on the 8 cycles after the accept edge; x_active=1 for those 8 cycles; word_done on the 8th; then x_out=1, x_active=0. Downstream detector flags a 0110 match.
- in_valid held high with words 8'hA5, 8'h3C -> 16 consecutive data bits with no idle gap. in_ready=0 from the edge after the second accept until the buffer drains. word_done pulses at cycles 8 and 16.
- MSB_FIRST=1 with word 8'h60 -> x_out 0,1,1,0,0,0,0,0. Same stream as the first scenario.
- in_valid pulses for one cycle every 12 cycles -> each word followed by exactly 4 cycles of x_out=1, x_active=0. busy=0 in the gaps.
- reset_n pulled low at bit index 3 of the first of two queued words -> x_out=1, x_active=0, busy=0, in_ready=1 immediately. No remaining bits from either word appear after release.
- in_valid held high with in_ready=0 and in_data changed while stalled -> the value present at the eventual accept edge is the one serialized.
